// File: rtl/pc_sequencer_if.sv
// Fetch-port and execute-unit handshake bundle for pc_sequencer.
// The master side is the sequencer, the slave side is memory plus execute unit.
interface pc_sequencer_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        exec_start;
    logic        exec_done;

    modport master (
        output mem_req,
        output mem_addr,
        output exec_start,
        input  mem_rdata,
        input  mem_ready,
        input  exec_done
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  exec_start,
        output mem_rdata,
        output mem_ready,
        output exec_done
    );
endinterface

// File: rtl/pc_sequencer.sv
// SLC-3 fetch/decode sequencer: owns PC and IR, resolves control flow,
// and hands every remaining opcode to the execute unit.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  HALT_VECT = 8'h25
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Run,
    input  logic           Continue,
    pc_sequencer_if.master hs,
    input  logic [2:0]     nzp,
    input  logic [15:0]    adder_out,
    input  logic [15:0]    bus_in,
    output logic [1:0]     pcmux_sel,
    output logic           ld_pc,
    output logic [15:0]    pc,
    output logic [15:0]    ir,
    output logic           r7_we,
    output logic [15:0]    r7_wdata,
    output logic           halted,
    output logic           paused
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_PAUSE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        continue_q;
    logic        mem_req;
    logic        exec_start;
    logic        ir_ld;
    logic [15:0] pc_mux;

    logic [3:0] opcode;
    logic       is_br;
    logic       is_jmp;
    logic       is_jsr;
    logic       is_pse;
    logic       is_halt;

    assign opcode  = ir[15:12];
    assign is_br   = (opcode == 4'b0000);
    assign is_jmp  = (opcode == 4'b1100);
    assign is_jsr  = (opcode == 4'b0100);
    assign is_pse  = (opcode == 4'b1101);
    assign is_halt = (opcode == 4'b1111) && (ir[7:0] == HALT_VECT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        ld_pc      = 1'b0;
        pcmux_sel  = 2'b00;
        r7_we      = 1'b0;
        exec_start = 1'b0;
        mem_req    = 1'b0;
        ir_ld      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Run) state_n = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (hs.mem_ready) begin
                    ir_ld   = 1'b1;
                    ld_pc   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_FETCH;
                unique case (1'b1)
                    is_br: begin
                        ld_pc     = |(ir[11:9] & nzp);
                        pcmux_sel = ld_pc ? 2'b01 : 2'b00;
                    end
                    is_jmp: begin
                        ld_pc     = 1'b1;
                        pcmux_sel = 2'b10;
                    end
                    // JSRR R7 sees the old R7 on bus_in; the link lands at this edge
                    is_jsr: begin
                        r7_we     = 1'b1;
                        ld_pc     = 1'b1;
                        pcmux_sel = ir[11] ? 2'b01 : 2'b10;
                    end
                    is_pse:  state_n = S_PAUSE;
                    is_halt: state_n = S_IDLE;
                    default: begin
                        exec_start = 1'b1;
                        state_n    = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                if (hs.exec_done) state_n = S_FETCH;
            end
            S_PAUSE: begin
                if (Continue && !continue_q) state_n = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (pcmux_sel)
            2'b00:   pc_mux = pc + 16'd1;
            2'b01:   pc_mux = adder_out;
            2'b10:   pc_mux = bus_in;
            default: pc_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc         <= RESET_PC;
            ir         <= 16'h0000;
            continue_q <= 1'b0;
        end else begin
            continue_q <= Continue;
            if (ld_pc) pc <= pc_mux;
            if (ir_ld) ir <= hs.mem_rdata;
        end
    end

    assign hs.mem_req    = mem_req;
    assign hs.mem_addr   = mem_req ? pc : 16'h0000;
    assign hs.exec_start = exec_start;
    assign r7_wdata      = r7_we ? pc : 16'h0000;
    assign halted        = (state == S_IDLE);
    assign paused        = (state == S_PAUSE);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode sequencer for the SLC-3 datapath. Owns the PC and IR registers and drives the 4-way PC multiplexer's select code plus the PC load strobe.
- Performs instruction fetch over a ready-handshake memory port.
- Resolves the control-flow instructions BR, JMP/RET, JSR/JSRR, PSE and HALT itself.
- Hands every other opcode to the external execute unit through a start/done handshake.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_VECT, 8'h25, TRAP vector (IR[7:0]) treated as HALT.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  level; starts execution from IDLE.
- Continue  in  1  level; rising edge resumes from PAUSE.
- mem_req  out  1  fetch request.
- mem_addr  out  16  fetch address; equals pc while mem_req=1.
- mem_rdata  in  16  fetched instruction; valid when mem_ready=1.
- mem_ready  in  1  fetch complete; may assert in the same cycle as mem_req.
- nzp  in  3  condition codes {N,Z,P}.
- adder_out  in  16  PC/base-plus-offset adder result (PCMUX code 01).
- bus_in  in  16  datapath bus value (BaseR for JMP/JSRR; PCMUX code 10).
- pcmux_sel  out  2  00=PC+1, 01=adder_out, 10=bus_in, 11=16'h0000.
- ld_pc  out  1  PC load strobe, mirrors the internal load.
- pc  out  16  current PC.
- ir  out  16  current IR.
- r7_we  out  1  write PC into R7 (JSR/JSRR link).
- r7_wdata  out  16  link value.
- exec_start  out  1  one-cycle pulse for non-control opcodes.
- exec_done  in  1  execute unit finished.
- halted  out  1  high in IDLE.
- paused  out  1  high in PAUSE.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, ir=0, continue_q=0, halted=1. All other outputs are 0; pcmux_sel=00.
- A Reset assertion mid-fetch or mid-exec drops mem_req and exec_start immediately, with no completion.
- Defaults each cycle: ld_pc=0, pcmux_sel=00, r7_we=0, exec_start=0.
- The PC register's next value is selected by pcmux_sel exactly per the code table, and is written only when ld_pc=1.
- continue_q registers Continue every cycle.

IDLE:
- halted=1. Run=1 → FETCH.
- pc is not reloaded on Run; a restart resumes at the current pc.

FETCH:
- mem_req=1, mem_addr=pc.
- mem_ready=0: stay.
- mem_ready=1: ir<=mem_rdata; ld_pc=1, sel=00 (pc<=pc+1, wraps FFFF→0000); → DECODE.
- Minimum fetch latency is 1 cycle.

DECODE (always exactly 1 cycle), by opcode ir[15:12]:
- 0000 BR: if (ir[11:9] & nzp)!=0, ld_pc=1, sel=01. BRnzp=000 never branches. → FETCH.
- 1100 JMP/RET: ld_pc=1, sel=10 → FETCH.
- 0100 JSR/JSRR:
  - r7_we=1, r7_wdata=pc (already incremented).
  - ld_pc=1, sel = ir[11] ? 01 : 10 → FETCH.
  - JSRR R7 uses bus_in sampled this cycle, i.e. the old R7, because the R7 write lands at the same edge.
- 1101 PSE: → PAUSE.
- 1111 with ir[7:0]==HALT_VECT: → IDLE.
- Any other opcode, including other TRAPs: exec_start=1 → EXEC.

EXEC:
- Wait for exec_done=1 → FETCH.
- exec_done arriving while not in EXEC is ignored.
- The execute unit may assert ld_pc externally only via this block's sel=11 path; that path is not used by this block.

PAUSE:
- paused=1.
- Continue=1 && continue_q=0 → FETCH.
- A Continue held high on entry does not resume; it must fall, then rise.

Run is ignored outside IDLE.

Test Plan:
- Reset with RESET_PC=16'h3000, Run pulse, mem_ready tied 1, mem_rdata=16'h1021 (ADD) → mem_addr=3000, ir=1021, pc=3001, exec_start one cycle after the fetch; exec_done → mem_addr=3001.
- BRz (16'h0405), nzp=010, adder_out=16'h3010 → in DECODE: ld_pc=1, sel=01; next fetch address 3010. Repeat with nzp=100 → no load, next fetch 3002.
- JSRR R7 (16'h41C0) at pc=3005, bus_in=16'h4000 → r7_we=1, r7_wdata=3006, sel=10, next fetch 4000.
- PSE (16'hD000) with Continue held 1 → remains paused. Continue 1→0→1 → fetch resumes at next pc.
- Fetch with mem_ready delayed 3 cycles, then Reset asserted mid-wait → mem_req drops asynchronously, pc=RESET_PC, halted=1. Also: TRAP x25 (16'hF025) → IDLE, halted=1, pc = address after the TRAP.
- pc=16'hFFFF, fetch NOP-class opcode → pc wraps to 16'h0000.
